logic_axi4_stream_packet_buffer: RTL and testbench

Single-clock AXI4-Stream store-and-forward packet buffer placed directly downstream of the AXI4-Stream clock crossing stage, in the consumer clock domain. It accepts beats from the crossing stage and holds them until a complete packet, terminated by `tlast`, is stored. It then releases the packet to the consumer without gaps. A packet longer than the buffer cannot be held whole, so the block falls back to cut-through forwarding for that packet instead of deadlocking.

---
 rtl/logic_axi4_stream_packet_buffer.sv | 123 ++++++++++++
 tb/tb_logic_axi4_stream_packet_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_stream_packet_buffer.sv
// AXI4-Stream store-and-forward packet buffer: holds beats until a whole packet is stored,
// then releases it gap-free; packets that overflow the memory are cut through instead.
module logic_axi4_stream_packet_buffer #(
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int USE_TKEEP   = 1,
  parameter int USE_TSTRB   = 1,
  parameter int CAPACITY    = 256
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             rx_tvalid,
  output logic                             rx_tready,
  input  logic                             rx_tlast,
  input  logic [TDATA_BYTES*8-1:0]         rx_tdata,
  input  logic [TDATA_BYTES-1:0]           rx_tstrb,
  input  logic [TDATA_BYTES-1:0]           rx_tkeep,
  input  logic [TDEST_WIDTH-1:0]           rx_tdest,
  input  logic [TUSER_WIDTH-1:0]           rx_tuser,
  input  logic [TID_WIDTH-1:0]             rx_tid,
  output logic                             tx_tvalid,
  input  logic                             tx_tready,
  output logic                             tx_tlast,
  output logic [TDATA_BYTES*8-1:0]         tx_tdata,
  output logic [TDATA_BYTES-1:0]           tx_tstrb,
  output logic [TDATA_BYTES-1:0]           tx_tkeep,
  output logic [TDEST_WIDTH-1:0]           tx_tdest,
  output logic [TUSER_WIDTH-1:0]           tx_tuser,
  output logic [TID_WIDTH-1:0]             tx_tid,
  output logic [$clog2(CAPACITY+1)-1:0]    packets
);

  localparam int DW = TDATA_BYTES * 8;
  localparam int BW = TDATA_BYTES;
  localparam int AW = $clog2(CAPACITY);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CAPACITY + 1);
  localparam int EW = DW + 2 * BW + TDEST_WIDTH + TUSER_WIDTH + TID_WIDTH + 1;

  typedef enum logic {STORE, FORWARD} state_t;

  state_t state;
  logic [EW-1:0] mem [CAPACITY];
  logic [PW-1:0] wr_ptr, rd_ptr, count, next_count;
  logic [EW-1:0] wr_word, rd_word;
  logic [BW-1:0] keep_in, strb_in, keep_q, strb_q;
  logic          head_last;
  logic [TID_WIDTH-1:0]   head_id;
  logic [TUSER_WIDTH-1:0] head_user;
  logic [TDEST_WIDTH-1:0] head_dest;
  logic [BW-1:0]          head_keep, head_strb;
  logic [DW-1:0]          head_data;
  logic ready_q, empty, pop_ok, push, pop;

  // Disabled sideband lanes are stored as constant ones so synthesis can prune them.
  assign keep_in = (USE_TKEEP != 0) ? rx_tkeep : '1;
  assign strb_in = (USE_TSTRB != 0) ? rx_tstrb : '1;
  assign wr_word = {rx_tlast, rx_tid, rx_tuser, rx_tdest, keep_in, strb_in, rx_tdata};
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign {head_last, head_id, head_user, head_dest, head_keep, head_strb, head_data} = rd_word;

  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign rx_tready  = ready_q;
  assign push       = rx_tvalid && ready_q;
  assign pop_ok     = !empty && ((state == FORWARD) || (packets != '0));
  assign pop        = pop_ok && (!tx_tvalid || tx_tready);
  assign next_count = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign tx_tkeep = (USE_TKEEP != 0) ? keep_q : '1;
  assign tx_tstrb = (USE_TSTRB != 0) ? strb_q : '1;

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ready_q   <= 1'b0;
      packets   <= '0;
      state     <= STORE;
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      tx_tdata  <= '0;
      strb_q    <= '0;
      keep_q    <= '0;
      tx_tdest  <= '0;
      tx_tuser  <= '0;
      tx_tid    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Ready looks one cycle ahead so it stays a pure register output.
      ready_q <= (next_count != PW'(CAPACITY));
      packets <= packets + CW'(push && rx_tlast) - CW'(pop && head_last);

      // A packet that fills memory with no tlast stored can never complete, so cut it through.
      case (state)
        STORE:   if (count == PW'(CAPACITY) && packets == '0) state <= FORWARD;
        FORWARD: if (pop && head_last) state <= STORE;
        default: state <= STORE;
      endcase

      if (pop) begin
        tx_tvalid <= 1'b1;
        tx_tlast  <= head_last;
        tx_tdata  <= head_data;
        strb_q    <= head_strb;
        keep_q    <= head_keep;
        tx_tdest  <= head_dest;
        tx_tuser  <= head_user;
        tx_tid    <= head_id;
      end else if (tx_tready) begin
        tx_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_axi4_stream_packet_buffer.sv
// Directed bench for the packet buffer at CAPACITY=8: latency, backpressure, full/wrap,
// oversize cut-through and mid-packet reset.
module tb_logic_axi4_stream_packet_buffer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        rx_tvalid = 1'b0, rx_tready, rx_tlast = 1'b0;
  logic [31:0] rx_tdata = '0;
  logic [3:0]  rx_tstrb = '1, rx_tkeep = '1;
  logic [0:0]  rx_tdest = '0, rx_tuser = '0, rx_tid = '0;
  logic        tx_tvalid, tx_tready = 1'b0, tx_tlast;
  logic [31:0] tx_tdata;
  logic [3:0]  tx_tstrb, tx_tkeep;
  logic [0:0]  tx_tdest, tx_tuser, tx_tid;
  logic [3:0]  packets;

  int checks = 0;
  int errors = 0;
  logic [32:0] txq[$];

  logic_axi4_stream_packet_buffer #(
    .TDATA_BYTES(4), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1),
    .USE_TKEEP(1), .USE_TSTRB(1), .CAPACITY(8)
  ) dut (
    .aclk(aclk), .areset(areset),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep),
    .rx_tdest(rx_tdest), .rx_tuser(rx_tuser), .rx_tid(rx_tid),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .tx_tdata(tx_tdata), .tx_tstrb(tx_tstrb), .tx_tkeep(tx_tkeep),
    .tx_tdest(tx_tdest), .tx_tuser(tx_tuser), .tx_tid(tx_tid),
    .packets(packets)
  );

  always #5 aclk = ~aclk;

  // Records every tx transfer; signals are stable at the falling edge before the handshake edge.
  always @(negedge aclk) begin
    if (!areset && tx_tvalid && tx_tready) txq.push_back({tx_tlast, tx_tdata});
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    logic acc;
    int n;
    n = 0;
    rx_tvalid = 1'b1;
    rx_tdata  = d;
    rx_tlast  = l;
    forever begin
      @(negedge aclk);
      acc = rx_tready;
      @(posedge aclk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("[TB] FAIL send_timeout data=%h never accepted", d);
        break;
      end
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget && txq.size() < n; c++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (rx_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_tready got=%b want=0", rx_tready); end
    checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_tvalid got=%b want=0", tx_tvalid); end
    checks++; if (packets !== 4'd0) begin errors++; $display("[TB] FAIL reset_packets got=%0d want=0", packets); end
    checks++; if (tx_tdata !== 32'h0 || tx_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_fields got=%h/%b want=0/0", tx_tdata, tx_tlast); end
    areset = 1'b0;
    @(posedge aclk);
    #1;
    checks++; if (rx_tready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_rx_tready got=%b want=1", rx_tready); end
  endtask

  task automatic test_single_packet();
    logic [31:0] exp_d;
    tx_tready = 1'b1;
    txq.delete();
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h11 * (i + 1), i == 3);
      checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid beat=%0d got=%b want=0", i, tx_tvalid); end
    end
    checks++; if (packets !== 4'd1) begin errors++; $display("[TB] FAIL single_packets_after_tlast got=%0d want=1", packets); end
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_d = 32'h11 * (i + 1);
      checks++;
      if (tx_tvalid !== 1'b1 || tx_tdata !== exp_d || tx_tlast !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL single_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, tx_tvalid, tx_tdata, tx_tlast, exp_d, i == 3);
      end
      @(posedge aclk);
      #1;
    end
    checks++; if (packets !== 4'd0) begin errors++; $display("[TB] FAIL single_packets_end got=%0d want=0", packets); end
    checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_end got=%b want=0", tx_tvalid); end
  endtask

  task automatic test_backpressure();
    logic [32:0] exp[8];
    logic        hold, held_l;
    logic [31:0] held_d;
    int          bad;
    exp = '{ {1'b1, 32'hA0}, {1'b0, 32'hB0}, {1'b1, 32'hB1}, {1'b0, 32'hC0},
             {1'b0, 32'hC1}, {1'b0, 32'hC2}, {1'b0, 32'hC3}, {1'b1, 32'hC4} };
    tx_tready = 1'b0;
    txq.delete();
    for (int i = 0; i < 8; i++) send_beat(exp[i][31:0], exp[i][32]);
    // A's tlast entry already sits in the output register, so only B and C are counted.
    checks++; if (packets !== 4'd2) begin errors++; $display("[TB] FAIL bp_packets_queued got=%0d want=2", packets); end
    checks++; if (tx_tvalid !== 1'b1 || tx_tdata !== 32'hA0) begin errors++; $display("[TB] FAIL bp_head got v=%b d=%h want v=1 d=a0", tx_tvalid, tx_tdata); end
    bad = 0;
    for (int c = 0; c < 400 && txq.size() < 8; c++) begin
      tx_tready = 1'($urandom_range(0, 1));
      hold   = tx_tvalid && !tx_tready;
      held_d = tx_tdata;
      held_l = tx_tlast;
      @(posedge aclk);
      #1;
      if (hold) begin
        checks++;
        if (tx_tvalid !== 1'b1 || tx_tdata !== held_d || tx_tlast !== held_l) begin
          errors++; bad++;
          if (bad < 5) $display("[TB] FAIL bp_stable got v=%b d=%h l=%b want v=1 d=%h l=%b", tx_tvalid, tx_tdata, tx_tlast, held_d, held_l);
        end
      end
    end
    tx_tready = 1'b0;
    checks++;
    if (txq.size() != 8) begin
      errors++; $display("[TB] FAIL bp_count got=%0d want=8", txq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (txq[i] !== exp[i]) begin errors++; $display("[TB] FAIL bp_order idx=%0d got=%h want=%h", i, txq[i], exp[i]); end
      end
    end
    checks++; if (packets !== 4'd0) begin errors++; $display("[TB] FAIL bp_packets_end got=%0d want=0", packets); end
    checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_end got=%b want=0", tx_tvalid); end
  endtask

  task automatic test_full_wrap();
    logic [32:0] exp_w;
    tx_tready = 1'b0;
    txq.delete();
    for (int i = 0; i < 9; i++) begin
      send_beat(32'h100 + i, 1'b1);
      if (i == 7) begin
        checks++; if (rx_tready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_at7 got=%b want=1", rx_tready); end
      end
    end
    // One beat lives in the output register, so the ninth accept is the one that fills memory.
    checks++; if (rx_tready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_drop got=%b want=0", rx_tready); end
    checks++; if (packets !== 4'd8) begin errors++; $display("[TB] FAIL full_packets got=%0d want=8", packets); end
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (rx_tready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_hold got=%b want=0", rx_tready); end
    tx_tready = 1'b1;
    send_beat(32'h109, 1'b1);
    for (int i = 0; i < 100; i++) send_beat(32'h200 + i, 1'b1);
    wait_beats(110, 300);
    checks++;
    if (txq.size() != 110) begin
      errors++; $display("[TB] FAIL wrap_count got=%0d want=110", txq.size());
    end else begin
      for (int i = 0; i < 110; i++) begin
        exp_w = (i < 10) ? {1'b1, 32'h100 + 32'(i)} : {1'b1, 32'h200 + 32'(i - 10)};
        checks++;
        if (txq[i] !== exp_w) begin errors++; $display("[TB] FAIL wrap_data idx=%0d got=%h want=%h", i, txq[i], exp_w); end
      end
    end
  endtask

  task automatic test_oversize();
    int bad;
    tx_tready = 1'b1;
    txq.delete();
    for (int i = 0; i < 8; i++) send_beat(32'h300 + i, 1'b0);
    checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL over_valid_at_full got=%b want=0", tx_tvalid); end
    checks++; if (rx_tready !== 1'b0) begin errors++; $display("[TB] FAIL over_ready_at_full got=%b want=0", rx_tready); end
    for (int i = 8; i < 20; i++) send_beat(32'h300 + i, i == 19);
    wait_beats(20, 200);
    checks++;
    if (txq.size() != 20) begin
      errors++; $display("[TB] FAIL over_count got=%0d want=20", txq.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (txq[i] !== {i == 19, 32'h300 + 32'(i)}) begin
          errors++; $display("[TB] FAIL over_data idx=%0d got=%h want=%h", i, txq[i], {i == 19, 32'h300 + 32'(i)});
        end
      end
    end
    send_beat(32'h400, 1'b0);
    bad = 0;
    repeat (3) begin
      @(posedge aclk);
      #1;
      if (tx_tvalid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL over_next_held got=%0d valid cycles want=0", bad); end
    send_beat(32'h401, 1'b1);
    checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL over_next_early got=%b want=0", tx_tvalid); end
    @(posedge aclk);
    #1;
    checks++; if (tx_tvalid !== 1'b1 || tx_tdata !== 32'h400) begin errors++; $display("[TB] FAIL over_next_release got v=%b d=%h want v=1 d=400", tx_tvalid, tx_tdata); end
    wait_beats(22, 50);
  endtask

  task automatic test_reset_mid();
    int bad;
    tx_tready = 1'b1;
    txq.delete();
    for (int i = 0; i < 3; i++) send_beat(32'h500 + i, 1'b0);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    checks++; if (rx_tready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready got=%b want=0", rx_tready); end
    checks++; if (tx_tvalid !== 1'b0 || packets !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset_state got v=%b p=%0d want v=0 p=0", tx_tvalid, packets); end
    areset = 1'b0;
    @(posedge aclk);
    #1;
    checks++; if (rx_tready !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_ready got=%b want=1", rx_tready); end
    bad = 0;
    repeat (5) begin
      @(posedge aclk);
      #1;
      if (tx_tvalid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL mid_stale_valid got=%0d cycles want=0", bad); end
    send_beat(32'h600, 1'b1);
    wait_beats(1, 20);
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (txq.size() != 1 || txq[0] !== {1'b1, 32'h600}) begin
      errors++; $display("[TB] FAIL mid_new_packet got n=%0d first=%h want n=1 first=%h", txq.size(), (txq.size() > 0) ? txq[0] : 33'h0, {1'b1, 32'h600});
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_full_wrap();
    test_oversize();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
